// File: rtl/page_table_walker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : page_table_walker_pkg
//  Description : Shared types and constants for the page-table walker:
//                exception codes, PTE layout, walker FSM states and the
//                per-PTE action produced by the checker.
//  Revision    : 1.0  initial release
// ============================================================================
package page_table_walker_pkg;

    localparam int PTE_WIDTH          = 64;
    localparam int VPN_BITS_PER_LEVEL = 9;
    localparam int PPN_WIDTH          = 44;

    typedef enum logic [1:0] {
        MMU_EXC_NONE         = 2'd0,
        MMU_EXC_PAGE_FAULT   = 2'd1,
        MMU_EXC_ACCESS_FAULT = 2'd2
    } mmu_exception_e;

    typedef struct packed {
        logic [9:0]           reserved;
        logic [PPN_WIDTH-1:0] ppn;
        logic [5:0]           rsvd;
        logic                 x;
        logic                 w;
        logic                 r;
        logic                 v;
    } pte_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } ptw_state_e;

    // Outcome of evaluating one PTE: step down one level or finish the walk
    typedef enum logic {
        PTE_ACT_DESCEND = 1'b0,
        PTE_ACT_DONE    = 1'b1
    } pte_action_e;

endpackage
`default_nettype wire

// File: rtl/page_table_walker_if.sv
`default_nettype none
// ============================================================================
//  Module      : page_table_walker_if
//  Description : Bundles the mmu translation handshake and the PTE memory
//                read port. The slave modport is the walker's view; the
//                master modport is the view of the mmu/memory environment.
//  Revision    : 1.0  initial release
// ============================================================================
interface page_table_walker_if
    import page_table_walker_pkg::*;
#(
    parameter int PHYS_MEM_SIZE = 18,
    parameter int PAGESIZE      = 12,
    parameter int VADDR_SIZE    = 48
) ();

    localparam int VPN_W = VADDR_SIZE - PAGESIZE;
    localparam int PFN_W = PHYS_MEM_SIZE - PAGESIZE;

    // mmu translation request / response
    logic                     req_valid_in;
    logic                     req_ready_out;
    logic [VPN_W-1:0]         req_vpn_in;
    logic [PFN_W-1:0]         root_pfn_in;
    logic                     resp_valid_out;
    logic                     resp_ready_in;
    logic [PFN_W-1:0]         resp_pfn_out;
    mmu_exception_e           resp_exception_out;

    // PTE memory read port
    logic                     mem_req_valid_out;
    logic                     mem_req_ready_in;
    logic [PHYS_MEM_SIZE-1:0] mem_req_addr_out;
    logic                     mem_resp_valid_in;
    logic [PTE_WIDTH-1:0]     mem_resp_data_in;

    modport slave (
        input  req_valid_in, req_vpn_in, root_pfn_in, resp_ready_in,
               mem_req_ready_in, mem_resp_valid_in, mem_resp_data_in,
        output req_ready_out, resp_valid_out, resp_pfn_out, resp_exception_out,
               mem_req_valid_out, mem_req_addr_out
    );

    modport master (
        output req_valid_in, req_vpn_in, root_pfn_in, resp_ready_in,
               mem_req_ready_in, mem_resp_valid_in, mem_resp_data_in,
        input  req_ready_out, resp_valid_out, resp_pfn_out, resp_exception_out,
               mem_req_valid_out, mem_req_addr_out
    );

endinterface
`default_nettype wire

// File: rtl/page_table_walker_pte_check.sv
`default_nettype none
// ============================================================================
//  Module      : page_table_walker_pte_check
//  Description : Purely combinational evaluation of one fetched PTE at a
//                given walk level: decides whether to descend, or finishes
//                with a PFN or a fault.
//  Revision    : 1.0  initial release
// ============================================================================
module page_table_walker_pte_check
    import page_table_walker_pkg::*;
#(
    parameter int PFN_W   = 6,
    parameter int VPN_W   = 36,
    parameter int LEVEL_W = 2
) (
    input  wire pte_t             pte_i,
    input  wire [LEVEL_W-1:0]     level_i,
    input  wire [VPN_W-1:0]       vpn_i,
    output pte_action_e           next_action_o,
    output logic [PFN_W-1:0]      next_table_pfn_o,
    output logic [PFN_W-1:0]      pfn_o,
    output mmu_exception_e        exception_o
);

    logic                 w_is_leaf;
    logic                 w_invalid;
    logic [31:0]          w_shamt;
    logic [PPN_WIDTH-1:0] w_low_mask;
    logic [PPN_WIDTH-1:0] w_vpn_ext;
    logic [PPN_WIDTH-1:0] w_leaf_pfn;
    logic                 w_misaligned;
    logic                 w_ppn_oob;
    logic                 w_pfn_oob;
    logic                 w_unused_pte_bits;

    assign w_is_leaf  = pte_i.r | pte_i.x;
    // Write-only pages are reserved encodings and fault like invalid PTEs
    assign w_invalid  = !pte_i.v || (pte_i.w && !pte_i.r);

    // Superpage leaves keep 9*level low VPN bits as the page offset
    assign w_shamt    = 32'(level_i) * 32'(VPN_BITS_PER_LEVEL);
    assign w_low_mask = ~({PPN_WIDTH{1'b1}} << w_shamt);
    assign w_vpn_ext  = PPN_WIDTH'(vpn_i);
    assign w_leaf_pfn = (pte_i.ppn & ~w_low_mask) | (w_vpn_ext & w_low_mask);

    assign w_misaligned = (level_i != '0) && ((pte_i.ppn & w_low_mask) != '0);
    assign w_ppn_oob    = (pte_i.ppn >> PFN_W) != '0;
    assign w_pfn_oob    = (w_leaf_pfn >> PFN_W) != '0;

    // Only the table PPN bits that can address physical memory are kept;
    // the rest are proven zero by the range check before descending.
    assign next_table_pfn_o  = pte_i.ppn[PFN_W-1:0];
    assign w_unused_pte_bits = ^{pte_i.reserved, pte_i.rsvd};

    // Fault priority: invalid, non-leaf at bottom, table out of range,
    // misaligned superpage, leaf out of range
    always_comb begin
        next_action_o = PTE_ACT_DONE;
        pfn_o         = '0;
        exception_o   = MMU_EXC_NONE;
        if (w_invalid) begin
            exception_o = MMU_EXC_PAGE_FAULT;
        end else if (!w_is_leaf) begin
            if (level_i == '0) begin
                exception_o = MMU_EXC_PAGE_FAULT;
            end else if (w_ppn_oob) begin
                exception_o = MMU_EXC_ACCESS_FAULT;
            end else begin
                next_action_o = PTE_ACT_DESCEND;
            end
        end else if (w_misaligned) begin
            exception_o = MMU_EXC_PAGE_FAULT;
        end else if (w_pfn_oob) begin
            exception_o = MMU_EXC_ACCESS_FAULT;
        end else begin
            pfn_o = w_leaf_pfn[PFN_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/page_table_walker.sv
`default_nettype none
// ============================================================================
//  Module      : page_table_walker
//  Description : Radix page-table walker. Accepts one translation miss at a
//                time, issues one PTE read per level on a single-outstanding
//                memory port and returns a PFN or an exception to the mmu.
//  Revision    : 1.0  initial release
// ============================================================================
module page_table_walker
    import page_table_walker_pkg::*;
#(
    parameter int PHYS_MEM_SIZE = 18,
    parameter int PAGESIZE      = 12,
    parameter int VADDR_SIZE    = 48
) (
    input  wire                 clk_in,
    input  wire                 rst_N_in,
    page_table_walker_if.slave  ptw_bus
);

    localparam int VPN_W   = VADDR_SIZE - PAGESIZE;
    localparam int PFN_W   = PHYS_MEM_SIZE - PAGESIZE;
    localparam int LEVELS  = VPN_W / VPN_BITS_PER_LEVEL;
    localparam int LEVEL_W = $clog2(LEVELS);

    ptw_state_e           state_q, state_d;
    logic [LEVEL_W-1:0]   level_q, level_d;
    logic [VPN_W-1:0]     vpn_q, vpn_d;
    logic [PFN_W-1:0]     table_pfn_q, table_pfn_d;
    logic [PFN_W-1:0]     resp_pfn_q, resp_pfn_d;
    mmu_exception_e       resp_exc_q, resp_exc_d;

    pte_action_e          w_action;
    logic [PFN_W-1:0]     w_next_table_pfn;
    logic [PFN_W-1:0]     w_pfn;
    mmu_exception_e       w_exc;
    logic [VPN_BITS_PER_LEVEL-1:0] w_vpn_idx;

    page_table_walker_pte_check #(
        .PFN_W   (PFN_W),
        .VPN_W   (VPN_W),
        .LEVEL_W (LEVEL_W)
    ) u_pte_check (
        .pte_i            (ptw_bus.mem_resp_data_in),
        .level_i          (level_q),
        .vpn_i            (vpn_q),
        .next_action_o    (w_action),
        .next_table_pfn_o (w_next_table_pfn),
        .pfn_o            (w_pfn),
        .exception_o      (w_exc)
    );

    // PTE index for the current level; address is derived from registered
    // state only, so it stays stable while a read is back-pressured
    assign w_vpn_idx = VPN_BITS_PER_LEVEL'(vpn_q >> (32'(level_q) * 32'(VPN_BITS_PER_LEVEL)));

    assign ptw_bus.req_ready_out      = (state_q == IDLE);
    assign ptw_bus.mem_req_valid_out  = (state_q == ISSUE);
    assign ptw_bus.mem_req_addr_out   = {table_pfn_q, PAGESIZE'({w_vpn_idx, 3'b000})};
    assign ptw_bus.resp_valid_out     = (state_q == RESP);
    assign ptw_bus.resp_pfn_out       = resp_pfn_q;
    assign ptw_bus.resp_exception_out = resp_exc_q;

    // Walk control: accept, issue read, evaluate PTE, hold result
    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        vpn_d       = vpn_q;
        table_pfn_d = table_pfn_q;
        resp_pfn_d  = resp_pfn_q;
        resp_exc_d  = resp_exc_q;
        case (state_q)
            IDLE: begin
                if (ptw_bus.req_valid_in) begin
                    vpn_d       = ptw_bus.req_vpn_in;
                    table_pfn_d = ptw_bus.root_pfn_in;
                    level_d     = LEVEL_W'(LEVELS - 1);
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (ptw_bus.mem_req_ready_in) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (ptw_bus.mem_resp_valid_in) begin
                    if (w_action == PTE_ACT_DESCEND) begin
                        table_pfn_d = w_next_table_pfn;
                        level_d     = level_q - 1'b1;
                        state_d     = ISSUE;
                    end else begin
                        resp_pfn_d  = w_pfn;
                        resp_exc_d  = w_exc;
                        state_d     = RESP;
                    end
                end
            end
            RESP: begin
                if (ptw_bus.resp_ready_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and walk context registers; reset abandons any walk in flight
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            state_q     <= IDLE;
            level_q     <= '0;
            vpn_q       <= '0;
            table_pfn_q <= '0;
            resp_pfn_q  <= '0;
            resp_exc_q  <= MMU_EXC_NONE;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            vpn_q       <= vpn_d;
            table_pfn_q <= table_pfn_d;
            resp_pfn_q  <= resp_pfn_d;
            resp_exc_q  <= resp_exc_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_page_table_walker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_page_table_walker
//  Description : Directed self-checking bench for page_table_walker with a
//                small PTE memory responder.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_page_table_walker;
    import page_table_walker_pkg::*;

    localparam int PHYS_MEM_SIZE = 18;
    localparam int PAGESIZE      = 12;
    localparam int VADDR_SIZE    = 48;

    logic clk_in   = 1'b0;
    logic rst_N_in = 1'b0;
    always #5 clk_in = ~clk_in;

    page_table_walker_if #(
        .PHYS_MEM_SIZE (PHYS_MEM_SIZE),
        .PAGESIZE      (PAGESIZE),
        .VADDR_SIZE    (VADDR_SIZE)
    ) bus ();

    page_table_walker #(
        .PHYS_MEM_SIZE (PHYS_MEM_SIZE),
        .PAGESIZE      (PAGESIZE),
        .VADDR_SIZE    (VADDR_SIZE)
    ) dut (
        .clk_in   (clk_in),
        .rst_N_in (rst_N_in),
        .ptw_bus  (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // PTE memory image and read log
    logic [17:0] mem_addr [8];
    logic [63:0] mem_data [8];
    int          mem_n = 0;
    logic [17:0] rd_log [64];
    int          rd_cnt = 0;
    int          rd_base = 0;
    logic        mem_mute = 1'b0;
    logic        inject_stray = 1'b0;

    task automatic check_value(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] mem_lookup(input logic [17:0] a);
        for (int i = 0; i < mem_n; i++) begin
            if (mem_addr[i] == a) return mem_data[i];
        end
        return 64'h0;
    endfunction

    task automatic new_table();
        mem_n   = 0;
        rd_base = rd_cnt;
    endtask

    task automatic add_pte(input logic [17:0] a, input logic [63:0] d);
        mem_addr[mem_n] = a;
        mem_data[mem_n] = d;
        mem_n++;
    endtask

    // Memory: answers each accepted read in the following cycle
    initial begin
        logic        hs;
        logic [17:0] a;
        bus.mem_resp_valid_in = 1'b0;
        bus.mem_resp_data_in  = 64'h0;
        forever begin
            @(negedge clk_in);
            hs = bus.mem_req_valid_out && bus.mem_req_ready_in;
            a  = bus.mem_req_addr_out;
            if (hs && rd_cnt < 64) begin
                rd_log[rd_cnt] = a;
                rd_cnt++;
            end
            @(posedge clk_in);
            #2;
            bus.mem_resp_valid_in = 1'b0;
            bus.mem_resp_data_in  = 64'h0;
            if (hs && !mem_mute) begin
                bus.mem_resp_valid_in = 1'b1;
                bus.mem_resp_data_in  = mem_lookup(a);
            end else if (inject_stray) begin
                bus.mem_resp_valid_in = 1'b1;
                bus.mem_resp_data_in  = 64'h801;
            end
        end
    end

    task automatic start_req(input logic [35:0] vpn, input logic [5:0] root);
        @(posedge clk_in);
        #2;
        bus.req_valid_in = 1'b1;
        bus.req_vpn_in   = vpn;
        bus.root_pfn_in  = root;
        @(posedge clk_in);
        #2;
        bus.req_valid_in = 1'b0;
        bus.req_vpn_in   = '1;
        bus.root_pfn_in  = '1;
    endtask

    // lat = index of the first cycle after the accept edge with resp_valid
    task automatic wait_resp(output int lat);
        lat = 0;
        do begin
            @(negedge clk_in);
            lat++;
        end while (!bus.resp_valid_out && lat < 100);
        check_value("resp_seen", 64'(bus.resp_valid_out), 64'h1);
    endtask

    task automatic run_walk(input logic [35:0] vpn, input logic [5:0] root,
                            output int lat, output logic [63:0] pfn, output logic [63:0] exc);
        start_req(vpn, root);
        wait_resp(lat);
        pfn = 64'(bus.resp_pfn_out);
        exc = 64'(bus.resp_exception_out);
        @(negedge clk_in);
        check_value("idle_after_resp", 64'(bus.req_ready_out), 64'h1);
    endtask

    task automatic add_four_level();
        add_pte(18'h01000, 64'h801);
        add_pte(18'h02000, 64'hC01);
        add_pte(18'h03000, 64'h1001);
        add_pte(18'h04000, 64'hFC03);
    endtask

    initial begin
        int          lat;
        logic [63:0] pfn;
        logic [63:0] exc;
        bus.req_valid_in     = 1'b0;
        bus.req_vpn_in       = '0;
        bus.root_pfn_in      = '0;
        bus.resp_ready_in    = 1'b1;
        bus.mem_req_ready_in = 1'b1;

        // Reset values
        #3;
        check_value("rst_req_ready", 64'(bus.req_ready_out), 64'h1);
        check_value("rst_resp_valid", 64'(bus.resp_valid_out), 64'h0);
        check_value("rst_mem_valid", 64'(bus.mem_req_valid_out), 64'h0);
        check_value("rst_resp_pfn", 64'(bus.resp_pfn_out), 64'h0);
        check_value("rst_mem_addr", 64'(bus.mem_req_addr_out), 64'h0);
        check_value("rst_exc", 64'(bus.resp_exception_out), 64'(MMU_EXC_NONE));
        @(posedge clk_in);
        #2;
        rst_N_in = 1'b1;

        // Reset while waiting for a PTE, then a stray response in IDLE
        new_table();
        add_pte(18'h01000, 64'h801);
        mem_mute = 1'b1;
        start_req(36'h0, 6'h01);
        repeat (3) @(negedge clk_in);
        check_value("wait_req_ready", 64'(bus.req_ready_out), 64'h0);
        check_value("wait_mem_valid", 64'(bus.mem_req_valid_out), 64'h0);
        #1 rst_N_in = 1'b0;
        #1;
        check_value("midrst_req_ready", 64'(bus.req_ready_out), 64'h1);
        check_value("midrst_resp_valid", 64'(bus.resp_valid_out), 64'h0);
        check_value("midrst_mem_valid", 64'(bus.mem_req_valid_out), 64'h0);
        @(posedge clk_in);
        #2;
        rst_N_in = 1'b1;
        mem_mute = 1'b0;
        @(negedge clk_in);
        inject_stray = 1'b1;
        @(negedge clk_in);
        inject_stray = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            check_value("stray_req_ready", 64'(bus.req_ready_out), 64'h1);
            check_value("stray_mem_valid", 64'(bus.mem_req_valid_out), 64'h0);
            check_value("stray_resp_valid", 64'(bus.resp_valid_out), 64'h0);
        end

        // Full 4-level walk
        new_table();
        add_four_level();
        run_walk(36'h0, 6'h01, lat, pfn, exc);
        check_value("walk4_latency", 64'(lat), 64'd9);
        check_value("walk4_pfn", pfn, 64'h3F);
        check_value("walk4_exc", exc, 64'(MMU_EXC_NONE));
        check_value("walk4_reads", 64'(rd_cnt - rd_base), 64'd4);
        check_value("walk4_addr0", 64'(rd_log[rd_base + 0]), 64'h1000);
        check_value("walk4_addr1", 64'(rd_log[rd_base + 1]), 64'h2000);
        check_value("walk4_addr2", 64'(rd_log[rd_base + 2]), 64'h3000);
        check_value("walk4_addr3", 64'(rd_log[rd_base + 3]), 64'h4000);

        // Invalid second-level PTE
        new_table();
        add_pte(18'h01000, 64'h801);
        add_pte(18'h02000, 64'h800);
        run_walk(36'h0, 6'h01, lat, pfn, exc);
        check_value("inval_reads", 64'(rd_cnt - rd_base), 64'd2);
        check_value("inval_exc", exc, 64'(MMU_EXC_PAGE_FAULT));
        check_value("inval_pfn", pfn, 64'h0);
        check_value("inval_latency", 64'(lat), 64'd5);

        // Aligned superpage leaf at level 1
        new_table();
        add_pte(18'h01000, 64'h801);
        add_pte(18'h02000, 64'hC01);
        add_pte(18'h03000, 64'h3);
        run_walk(36'h15, 6'h01, lat, pfn, exc);
        check_value("super_pfn", pfn, 64'h15);
        check_value("super_exc", exc, 64'(MMU_EXC_NONE));
        check_value("super_reads", 64'(rd_cnt - rd_base), 64'd3);

        // Misaligned superpage leaf at level 1
        new_table();
        add_pte(18'h01000, 64'h801);
        add_pte(18'h02000, 64'hC01);
        add_pte(18'h03000, 64'h403);
        run_walk(36'h15, 6'h01, lat, pfn, exc);
        check_value("misal_exc", exc, 64'(MMU_EXC_PAGE_FAULT));
        check_value("misal_pfn", pfn, 64'h0);

        // Non-leaf pointing outside physical memory
        new_table();
        add_pte(18'h01000, 64'h10001);
        run_walk(36'h0, 6'h01, lat, pfn, exc);
        check_value("oob_exc", exc, 64'(MMU_EXC_ACCESS_FAULT));
        check_value("oob_pfn", pfn, 64'h0);
        check_value("oob_latency", 64'(lat), 64'd3);
        repeat (2) @(negedge clk_in);
        check_value("oob_mem_valid", 64'(bus.mem_req_valid_out), 64'h0);
        check_value("oob_reads", 64'(rd_cnt - rd_base), 64'd1);

        // Back-pressure on both ports, request pulses while busy
        new_table();
        add_four_level();
        bus.mem_req_ready_in = 1'b0;
        bus.resp_ready_in    = 1'b0;
        start_req(36'h0, 6'h01);
        bus.req_valid_in = 1'b1;
        bus.req_vpn_in   = 36'h123456789;
        bus.root_pfn_in  = 6'h02;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            check_value("bp_mem_valid", 64'(bus.mem_req_valid_out), 64'h1);
            check_value("bp_mem_addr", 64'(bus.mem_req_addr_out), 64'h1000);
            check_value("bp_req_ready", 64'(bus.req_ready_out), 64'h0);
        end
        @(posedge clk_in);
        #2;
        bus.req_valid_in     = 1'b0;
        bus.mem_req_ready_in = 1'b1;
        wait_resp(lat);
        for (int i = 0; i < 2; i++) begin
            if (i > 0) @(negedge clk_in);
            check_value("bp_resp_valid", 64'(bus.resp_valid_out), 64'h1);
            check_value("bp_resp_pfn", 64'(bus.resp_pfn_out), 64'h3F);
            check_value("bp_resp_exc", 64'(bus.resp_exception_out), 64'(MMU_EXC_NONE));
            check_value("bp_busy_ready", 64'(bus.req_ready_out), 64'h0);
        end
        @(posedge clk_in);
        #2;
        bus.resp_ready_in = 1'b1;
        @(negedge clk_in);
        check_value("bp_resp_hold", 64'(bus.resp_valid_out), 64'h1);
        @(negedge clk_in);
        check_value("bp_done_ready", 64'(bus.req_ready_out), 64'h1);
        check_value("bp_done_valid", 64'(bus.resp_valid_out), 64'h0);
        check_value("bp_reads", 64'(rd_cnt - rd_base), 64'd4);
        check_value("bp_last_addr", 64'(rd_log[rd_base + 3]), 64'h4000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
